// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch/data share one in-order memory port.
// Grants are combinational; a per-transaction source FIFO routes each response back.
module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [3:0]  m_we,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(STARVE_LIMIT);

    logic [MAX_OUTSTANDING-1:0] fifo_r;
    logic [PW-1:0]              rd_ptr_r;
    logic [PW-1:0]              wr_ptr_r;
    logic [CW-1:0]              count_r;
    logic [WW-1:0]              wait_cnt_r;
    logic                       lock_valid_r;
    logic                       lock_sel_r;
    logic                       err_r;

    logic full_s;
    logic empty_s;
    logic m_req_s;
    logic sel_i_s;
    logic accept_s;
    logic pop_s;
    logic head_s;

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Arbitration: stalled selection is locked, then starvation override, then data priority.
    always_comb begin
        full_s   = (count_r == COUNT_FULL);
        empty_s  = (count_r == {CW{1'b0}});
        m_req_s  = (i_req | d_req) & ~full_s & ~rst;
        if (lock_valid_r) begin
            sel_i_s = lock_sel_r;
        end else if ((wait_cnt_r == WAIT_MAX) && i_req) begin
            sel_i_s = 1'b1;
        end else if (d_req) begin
            sel_i_s = 1'b0;
        end else begin
            sel_i_s = 1'b1;
        end
        accept_s = m_req_s & m_gnt;
        head_s   = fifo_r[rd_ptr_r];
        pop_s    = m_rvalid & ~empty_s & ~rst;
    end

    // Memory-side mux, grants and response routing.
    always_comb begin
        m_req = m_req_s;
        if (sel_i_s) begin
            m_addr  = i_addr;
            m_we    = 4'b0000;
            m_wdata = 32'h0000_0000;
        end else begin
            m_addr  = d_addr;
            m_we    = d_we;
            m_wdata = d_wdata;
        end
        i_gnt    = accept_s & sel_i_s;
        d_gnt    = accept_s & ~sel_i_s;
        i_rvalid = pop_s & head_s;
        d_rvalid = pop_s & ~head_s;
        i_rdata  = m_rdata;
        d_rdata  = m_rdata;
        err      = err_r;
    end

    // Selection lock, fetch starvation counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_valid_r <= 1'b0;
            lock_sel_r   <= 1'b0;
            wait_cnt_r   <= {WW{1'b0}};
            err_r        <= 1'b0;
        end else begin
            lock_valid_r <= m_req_s & ~m_gnt;
            lock_sel_r   <= sel_i_s;
            if (~i_req | (accept_s & sel_i_s)) begin
                wait_cnt_r <= {WW{1'b0}};
            end else if (accept_s && (wait_cnt_r != WAIT_MAX)) begin
                wait_cnt_r <= wait_cnt_r + WW'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (m_rvalid & empty_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Source FIFO: one bit per accepted transaction, 1 = fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_r   <= {MAX_OUTSTANDING{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (accept_s) begin
                fifo_r[wr_ptr_r] <= sel_i_s;
                wr_ptr_r         <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: reference arbitration model, memory model and
// response scoreboard, plus directed sequences for the stall/starve/full cases.
module tb_mem_arbiter;

    localparam int MAXO = 2;
    localparam int SL   = 4;

    logic        clk;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_we;
    logic        m_req, m_gnt, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_we;
    logic        err;

    mem_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic fetch; logic [31:0] data; } sb_t;
    typedef struct { logic [31:0] data; int due; } mem_t;
    sb_t  sb_q[$];
    mem_t mem_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // stimulus knobs
    int i_pct = 0, d_pct = 0, gnt_pct = 100, lat_max = 1;
    bit hold_rv = 1'b0, spur = 1'b0, d_fixed = 1'b0;

    // requester and model state
    bit          i_pend, d_pend;
    logic [31:0] i_addr_v, d_addr_v, d_wdata_v;
    logic [3:0]  d_we_v;
    int          mcount, mwait;
    bit          mlock_v, mlock_sel, merr;
    logic [7:0]  acc_hist, igr_hist;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [31:0] resp_of(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        return {a[15:0], a[31:16]} ^ wd ^ {28'h0, we} ^ 32'h5A5A_0000;
    endfunction

    // One clock cycle: drive after the edge, check and update models on the falling edge.
    task automatic cycle();
        bit          exp_mreq, exp_sel, exp_acc, exp_pop, mem_rv;
        sb_t         head;
        if (!i_pend && $urandom_range(99, 0) < i_pct) begin
            i_pend   = 1'b1;
            i_addr_v = 32'($urandom) & 32'hFFFF_FFFC;
        end
        if (!d_pend && $urandom_range(99, 0) < d_pct) begin
            d_pend    = 1'b1;
            d_addr_v  = d_fixed ? 32'h0000_0100 : (32'($urandom) & 32'hFFFF_FFFC);
            d_we_v    = d_fixed ? 4'b0011 : 4'($urandom_range(15, 0));
            d_wdata_v = 32'($urandom);
        end
        i_req   = i_pend;  i_addr  = i_addr_v;
        d_req   = d_pend;  d_addr  = d_addr_v;  d_we = d_we_v;  d_wdata = d_wdata_v;
        m_gnt   = ($urandom_range(99, 0) < gnt_pct);
        m_rvalid = 1'b0;   m_rdata = 32'h0;     mem_rv = 1'b0;
        if (!rst) begin
            if (spur) begin
                m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
            end else if (!hold_rv && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                m_rvalid = 1'b1; m_rdata = mem_q[0].data; mem_rv = 1'b1;
            end
        end
        @(negedge clk);
        exp_mreq = (i_req | d_req) && (mcount != MAXO) && !rst;
        if (mlock_v)                    exp_sel = mlock_sel;
        else if (mwait == SL && i_req)  exp_sel = 1'b1;
        else if (d_req)                 exp_sel = 1'b0;
        else                            exp_sel = 1'b1;
        exp_acc = exp_mreq && m_gnt;
        exp_pop = m_rvalid && (mcount != 0) && !rst;
        check_eq("m_req", m_req, exp_mreq);
        check_eq("i_gnt", i_gnt, exp_acc && exp_sel);
        check_eq("d_gnt", d_gnt, exp_acc && !exp_sel);
        check_eq("err", err, merr);
        if (exp_mreq) begin
            check_eq("m_addr", m_addr, exp_sel ? i_addr : d_addr);
            check_eq("m_we", m_we, exp_sel ? 4'b0000 : d_we);
            check_eq("m_wdata", m_wdata, exp_sel ? 32'h0 : d_wdata);
        end
        if (exp_pop && sb_q.size() > 0) begin
            head = sb_q.pop_front();
            check_eq("i_rvalid", i_rvalid, head.fetch);
            check_eq("d_rvalid", d_rvalid, !head.fetch);
            check_eq("rdata", head.fetch ? i_rdata : d_rdata, head.data);
        end else begin
            check_eq("i_rvalid", i_rvalid, 1'b0);
            check_eq("d_rvalid", d_rvalid, 1'b0);
        end
        acc_hist = {acc_hist[6:0], m_req & m_gnt};
        igr_hist = {igr_hist[6:0], i_gnt};
        // memory side follows what the DUT actually presented
        if (mem_rv) void'(mem_q.pop_front());
        if (m_req && m_gnt && !rst)
            mem_q.push_back('{resp_of(m_addr, m_we, m_wdata), cyc + int'($urandom_range(lat_max, 1))});
        if (exp_acc) begin
            if (exp_sel) sb_q.push_back('{1'b1, resp_of(i_addr, 4'b0000, 32'h0)});
            else         sb_q.push_back('{1'b0, resp_of(d_addr, d_we, d_wdata)});
            if (exp_sel) i_pend = 1'b0;
            else         d_pend = 1'b0;
        end
        if (rst) begin
            mcount = 0; mwait = 0; mlock_v = 1'b0; merr = 1'b0;
            i_pend = 1'b0; d_pend = 1'b0;
            sb_q.delete(); mem_q.delete();
        end else begin
            mlock_v   = exp_mreq && !m_gnt;
            mlock_sel = exp_sel;
            if (!i_req || (exp_acc && exp_sel)) mwait = 0;
            else if (exp_acc && mwait < SL)     mwait++;
            if (m_rvalid && mcount == 0) merr = 1'b1;
            mcount = mcount + int'(exp_acc) - int'(exp_pop);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        i_pct = 0; d_pct = 0; gnt_pct = 100; hold_rv = 1'b0; spur = 1'b0; lat_max = 1;
        repeat (10) cycle();
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_we = 4'h0; d_wdata = 32'h0; m_rdata = 32'h0;
        i_pend = 1'b0; d_pend = 1'b0; i_addr_v = 32'h0; d_addr_v = 32'h0;
        d_wdata_v = 32'h0; d_we_v = 4'h0;
        mcount = 0; mwait = 0; mlock_v = 1'b0; mlock_sel = 1'b0; merr = 1'b0;
        acc_hist = 8'h0; igr_hist = 8'h0;
        @(posedge clk); #1;
        repeat (2) cycle();
        rst = 1'b0;

        // simultaneous requests: data first, fetch next
        i_pct = 100; d_pct = 100; cycle(); d_pct = 0; cycle();
        check_eq("simul_acc", {30'h0, acc_hist[1:0]}, 32'h3);
        check_eq("simul_igr", {30'h0, igr_hist[1:0]}, 32'h1);
        drain();

        // continuous data traffic starves fetch for exactly SL grants
        i_pct = 100; d_pct = 100;
        repeat (5) cycle();
        check_eq("starve_acc", {27'h0, acc_hist[4:0]}, 32'h1F);
        check_eq("starve_igr", {27'h0, igr_hist[4:0]}, 32'h01);
        drain();

        // fetch stalled by memory; data arrives during the stall
        i_pct = 100; gnt_pct = 0; cycle();
        d_pct = 100; repeat (2) cycle();
        i_pct = 0; gnt_pct = 100; cycle();
        check_eq("lock_acc", {28'h0, acc_hist[3:0]}, 32'h1);
        check_eq("lock_igr", {28'h0, igr_hist[3:0]}, 32'h1);
        drain();

        // outstanding limit and the one-cycle bubble on release
        i_pct = 100; hold_rv = 1'b1; repeat (4) cycle();
        hold_rv = 1'b0; repeat (2) cycle();
        check_eq("full_acc", {26'h0, acc_hist[5:0]}, 32'h31);
        drain();

        // partial store at 0x100, acked as d_rvalid
        d_fixed = 1'b1; d_pct = 100; cycle(); d_pct = 0; d_fixed = 1'b0;
        check_eq("store_dgnt", {31'h0, d_gnt}, 32'h1);
        drain();

        // random traffic with variable memory latency and stalls
        i_pct = 50; d_pct = 50; gnt_pct = 70; lat_max = 3;
        repeat (300) cycle();
        drain();

        // spurious response with nothing outstanding
        spur = 1'b1; cycle(); spur = 1'b0;
        repeat (3) cycle();
        check_eq("err_sticky", {31'h0, err}, 32'h1);

        // reset in the middle of outstanding transactions
        i_pct = 100; d_pct = 100; hold_rv = 1'b1; repeat (3) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        i_pct = 0; d_pct = 0; hold_rv = 1'b0; cycle();
        check_eq("rst_err", {31'h0, err}, 32'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
